// File: rtl/unified_mem_arbiter_pkg.sv
// unified_mem_arbiter_pkg: encodings shared by the core
// datapath and the unified memory arbiter.
package unified_mem_arbiter_pkg;

  localparam logic [2:0] DM_WORD     = 3'b000;
  localparam logic [2:0] DM_HALF     = 3'b001;
  localparam logic [2:0] DM_HALF_U   = 3'b010;
  localparam logic [2:0] DM_BYTE     = 3'b011;
  localparam logic [2:0] DM_BYTE_U   = 3'b100;

  localparam logic [1:0] WDSEL_ALU   = 2'b00;
  localparam logic [1:0] WDSEL_MEM   = 2'b01;
  localparam logic [1:0] WDSEL_PC    = 2'b10;

  localparam logic [1:0] ARB_IDLE    = 2'b00;
  localparam logic [1:0] ARB_IBUSY   = 2'b01;
  localparam logic [1:0] ARB_DBUSY   = 2'b10;

  localparam logic       GNT_I       = 1'b0;
  localparam logic       GNT_D       = 1'b1;

  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/unified_mem_arbiter_watchdog.sv
// unified_mem_arbiter_watchdog: counts busy cycles and flags
// expiry on the TIMEOUT-th one.
// Ports: clk, reset, busy (arbiter owns the bus), expired.
// The count restarts whenever the arbiter goes idle, so each
// grant begins a fresh window.
module unified_mem_arbiter_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic busy,
  output logic expired
);

  localparam logic [7:0] LIM = 8'(TIMEOUT - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (busy) begin
      cnt <= cnt + 8'd1;
    end else begin
      cnt <= '0;
    end
  end

  assign expired = busy && (cnt == LIM);

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one variable-latency memory
// between the fetch (i_*) and load/store (d_*) ports.
// Ports: i_req/i_addr -> i_ack/i_rdata/i_stall,
//   d_req/d_we/d_dmtype/d_addr/d_wdata -> d_ack/d_rdata/d_stall,
//   mem_* handshake to memory, busy, grant_d.
// Optional MEM_ARB_TIMEOUT_EN adds timeout_err and a watchdog.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_dmtype,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [2:0]        mem_dmtype,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_d
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  logic [1:0]        state;
  logic              last_grant;
  logic              i_eff;
  logic              d_eff;
  logic              pick_d;
  logic              expired;
  logic              done;
  logic [DATA_W-1:0] to_data;

  // A requester still holding req in its ack cycle is not
  // re-granted; D wins a collision unless it won the last one.
  assign i_eff   = i_req & ~i_ack;
  assign d_eff   = d_req & ~d_ack;
  assign pick_d  = d_eff & (~i_eff | (last_grant == GNT_I));
  assign busy    = (state != ARB_IDLE);
  assign i_stall = i_req & ~i_ack;
  assign d_stall = d_req & ~d_ack;
  assign to_data = DATA_W'(ARB_TIMEOUT_DATA);
  assign done    = mem_ready | expired;

`ifdef MEM_ARB_TIMEOUT_EN
  unified_mem_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .busy    (busy),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
    end else if (expired && !mem_ready) begin
      timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign expired        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB_IDLE;
      last_grant <= GNT_I;
      i_ack      <= 1'b0;
      d_ack      <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_dmtype <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      grant_d    <= 1'b0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (i_eff || d_eff) begin
            mem_req    <= 1'b1;
            last_grant <= pick_d;
            grant_d    <= pick_d;
            if (pick_d) begin
              mem_we     <= d_we;
              mem_dmtype <= d_dmtype;
              mem_addr   <= d_addr;
              mem_wdata  <= d_wdata;
              state      <= ARB_DBUSY;
            end else begin
              mem_we     <= 1'b0;
              mem_dmtype <= DM_WORD;
              mem_addr   <= i_addr;
              mem_wdata  <= '0;
              state      <= ARB_IBUSY;
            end
          end
        end
        ARB_IBUSY: begin
          if (done) begin
            i_ack   <= 1'b1;
            i_rdata <= mem_ready ? mem_rdata : to_data;
            mem_req <= 1'b0;
            state   <= ARB_IDLE;
          end
        end
        ARB_DBUSY: begin
          if (done) begin
            d_ack   <= 1'b1;
            d_rdata <= !mem_ready ? to_data :
                       mem_we     ? '0      : mem_rdata;
            mem_req <= 1'b0;
            state   <= ARB_IDLE;
          end
        end
        default: begin
          mem_req <= 1'b0;
          state   <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: scoreboard bench with a
// variable-latency memory model and auto-advancing requesters.
module tb_unified_mem_arbiter;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  localparam logic [2:0] WORD = 3'b000;

  typedef struct packed {
    logic        we;
    logic [2:0]  dm;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic        i_ack;
  logic [31:0] i_rdata;
  logic        i_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_dmtype = '0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_stall;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  mem_dmtype;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        busy;
  logic        grant_d;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  unified_mem_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_ack      (i_ack),
    .i_rdata    (i_rdata),
    .i_stall    (i_stall),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_dmtype   (d_dmtype),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .d_stall    (d_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_dmtype (mem_dmtype),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .grant_d    (grant_d)
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          wcnt = 0;
  int          mem_lat = 0;
  bit          mem_hang = 1'b0;
  bit          stray = 1'b0;
  bit          exp_to = 1'b0;
  int          ready_cyc = 0;
  int          i_launch_cyc = 0;
  int          d_launch_cyc = 0;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_we;
  logic [2:0]  cur_dm;

  logic [31:0] i_stim[$];
  dreq_t       d_stim[$];
  logic [31:0] i_q[$];
  logic [31:0] d_q[$];
  bit          gnt_exp[$];
  bit          ack_log[$];
  int          ack_cyc[$];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h10)  return 32'h0000_0013;
    if (a == 32'h300) return 32'h1234_5678;
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cyc %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    bit    g;
    dreq_t dr;
    @(posedge clk);
    cyc++;
    #1;
    if (!reset && mem_req) begin
      if (wcnt == 0) begin
        if (gnt_exp.size() == 0) begin
          chk("gnt_unexp", 32'(mem_req), 32'd0);
        end else begin
          g = gnt_exp.pop_front();
          chk("grant_d", 32'(grant_d), 32'(g));
          chk("mem_we", 32'(mem_we), 32'(g & d_we));
          chk("mem_dmtype", 32'(mem_dmtype),
              32'(g ? d_dmtype : WORD));
          chk("mem_addr", mem_addr, g ? d_addr : i_addr);
          if (g && d_we) chk("mem_wdata", mem_wdata, d_wdata);
        end
        cur_addr  = mem_addr;
        cur_wdata = mem_wdata;
        cur_we    = mem_we;
        cur_dm    = mem_dmtype;
      end else begin
        chk("addr_stable", mem_addr, cur_addr);
        chk("wdata_stable", mem_wdata, cur_wdata);
        chk("we_stable", 32'(mem_we), 32'(cur_we));
        chk("dm_stable", 32'(mem_dmtype), 32'(cur_dm));
      end
      mem_ready = !mem_hang && (wcnt >= mem_lat);
      if (mem_ready) ready_cyc = cyc;
      mem_rdata = mem_ready ? mem_fn(mem_addr) : 32'hBAD0_BAD0;
      wcnt++;
    end else begin
      wcnt      = 0;
      mem_ready = stray && !reset;
      mem_rdata = 32'h0BAD_0000;
    end
    @(negedge clk);
    chk("i_stall", 32'(i_stall), 32'(i_req & ~i_ack));
    chk("d_stall", 32'(d_stall), 32'(d_req & ~d_ack));
    chk("ack_overlap", 32'(i_ack & d_ack), 32'd0);
    if (i_ack) begin
      if (i_q.size() == 0) chk("i_ack_unexp", 32'(i_ack), 32'd0);
      else chk("i_rdata", i_rdata, i_q.pop_front());
      ack_log.push_back(1'b0);
      ack_cyc.push_back(cyc);
    end
    if (d_ack) begin
      if (d_q.size() == 0) chk("d_ack_unexp", 32'(d_ack), 32'd0);
      else chk("d_rdata", d_rdata, d_q.pop_front());
      ack_log.push_back(1'b1);
      ack_cyc.push_back(cyc);
    end
    if (!reset && (i_ack || !i_req)) begin
      if (i_stim.size() > 0) begin
        i_req  = 1'b1;
        i_addr = i_stim.pop_front();
        i_q.push_back(exp_to ? 32'hDEAD_BEEF : mem_fn(i_addr));
        i_launch_cyc = cyc;
      end else begin
        i_req = 1'b0;
      end
    end
    if (!reset && (d_ack || !d_req)) begin
      if (d_stim.size() > 0) begin
        dr       = d_stim.pop_front();
        d_req    = 1'b1;
        d_we     = dr.we;
        d_dmtype = dr.dm;
        d_addr   = dr.addr;
        d_wdata  = dr.wdata;
        d_q.push_back(exp_to ? 32'hDEAD_BEEF :
                      dr.we  ? 32'h0 : mem_fn(dr.addr));
        d_launch_cyc = cyc;
      end else begin
        d_req = 1'b0;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (n < budget &&
           (i_stim.size() + d_stim.size() +
            i_q.size() + d_q.size() != 0 || i_req || d_req)) begin
      tick();
      n++;
    end
    chk(tag, 32'(i_stim.size() + d_stim.size() +
                 i_q.size() + d_q.size()), 32'd0);
    chk({tag, "_gnt"}, 32'(gnt_exp.size()), 32'd0);
  endtask

  task automatic clr_log();
    ack_log.delete();
    ack_cyc.delete();
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_i_ack", 32'(i_ack), 32'd0);
    chk("rst_d_ack", 32'(d_ack), 32'd0);
    chk("rst_grant_d", 32'(grant_d), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    reset = 1'b0;

    // first collision after reset: D wins, store returns 0
    clr_log();
    d_stim.push_back('{1'b1, WORD, 32'h200, 32'hA5A5_A5A5});
    i_stim.push_back(32'h10);
    gnt_exp.push_back(1'b1);
    gnt_exp.push_back(1'b0);
    drain("t2_drain", 40);
    chk("t2_nack", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() == 2) begin
      chk("t2_first_d", 32'(ack_log[0]), 32'd1);
      chk("t2_then_i", 32'(ack_log[1]), 32'd0);
      chk("t2_gap", 32'(ack_cyc[1] - ack_cyc[0]), 32'd2);
    end

    // single fetch, minimum latency
    clr_log();
    i_stim.push_back(32'h10);
    gnt_exp.push_back(1'b0);
    drain("t1_drain", 40);
    chk("t1_nack", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1)
      chk("t1_latency", 32'(ack_cyc[0] - i_launch_cyc), 32'd2);

    // continuous collision stream alternates D, I
    clr_log();
    for (int k = 0; k < 4; k++) begin
      i_stim.push_back(32'h1000 + 32'(4 * k));
      d_stim.push_back('{k[0], 3'(k), 32'h2000 + 32'(4 * k),
                         32'h5500_0000 + 32'(k)});
      gnt_exp.push_back(1'b1);
      gnt_exp.push_back(1'b0);
    end
    drain("t3_drain", 80);
    chk("t3_nack", 32'(ack_log.size()), 32'd8);
    if (ack_log.size() == 8) begin
      for (int k = 0; k < 8; k++)
        chk("t3_order", 32'(ack_log[k]), 32'(k % 2 == 0));
      for (int k = 1; k < 8; k++)
        chk("t3_gap", 32'(ack_cyc[k] - ack_cyc[k-1]), 32'd2);
    end

    // slow memory: ready 5 cycles late
    clr_log();
    mem_lat = 5;
    d_stim.push_back('{1'b0, 3'b010, 32'h300, 32'h0});
    gnt_exp.push_back(1'b1);
    drain("t4_drain", 60);
    mem_lat = 0;
    chk("t4_nack", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1) begin
      chk("t4_ack_after_rdy", 32'(ack_cyc[0] - ready_cyc), 32'd1);
      chk("t4_latency", 32'(ack_cyc[0] - d_launch_cyc), 32'd7);
    end

    // mem_ready while idle is ignored
    stray = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_idle_busy", 32'(busy), 32'd0);
      chk("t5_idle_req", 32'(mem_req), 32'd0);
    end
    stray = 1'b0;

    // reset in the middle of a data transaction
    clr_log();
    mem_hang = 1'b1;
    d_stim.push_back('{1'b0, WORD, 32'h400, 32'h0});
    gnt_exp.push_back(1'b1);
    tick();
    tick();
    tick();
    chk("t6_busy_pre", 32'(busy), 32'd1);
    reset = 1'b1;
    d_req = 1'b0;
    d_q.delete();
    tick();
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_mem_req", 32'(mem_req), 32'd0);
    chk("t6_d_ack", 32'(d_ack), 32'd0);
    reset = 1'b0;
    mem_hang = 1'b0;
    tick();
    chk("t6_no_late_ack", 32'(d_ack), 32'd0);
    i_stim.push_back(32'h10);
    gnt_exp.push_back(1'b0);
    drain("t6_drain", 40);
    chk("t6_nack", 32'(ack_log.size()), 32'd1);

`ifdef MEM_ARB_TIMEOUT_EN
    // watchdog expiry with a dead memory
    clr_log();
    chk("t7_err_clear", 32'(timeout_err), 32'd0);
    mem_hang = 1'b1;
    exp_to = 1'b1;
    d_stim.push_back('{1'b0, WORD, 32'h500, 32'h0});
    gnt_exp.push_back(1'b1);
    drain("t7_drain", 60);
    exp_to = 1'b0;
    mem_hang = 1'b0;
    chk("t7_nack", 32'(ack_log.size()), 32'd1);
    if (ack_log.size() == 1)
      chk("t7_latency", 32'(ack_cyc[0] - d_launch_cyc), 32'(TO + 1));
    chk("t7_err_set", 32'(timeout_err), 32'd1);
    i_stim.push_back(32'h10);
    gnt_exp.push_back(1'b0);
    drain("t7_drain2", 40);
    chk("t7_err_sticky", 32'(timeout_err), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t7_err_rst", 32'(timeout_err), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch port and load/store port.
- Sits between the 5-stage core and the memory.
- Latches a request, drives the memory handshake and returns read data with a one-cycle ack pulse.
- Produces per-port stall signals that the core ORs into its hazard stall.
- Round-robin arbitration when both ports collide; data side wins the first collision after reset.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- TIMEOUT, 255, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; level-held until i_ack
- i_addr  in  ADDR_W  fetch address
- i_ack  out  1  one-cycle completion pulse, fetch
- i_rdata  out  DATA_W  fetched instruction; valid when i_ack=1
- i_stall  out  1  i_req & ~i_ack (combinational)
- d_req  in  1  load/store request; level-held until d_ack
- d_we  in  1  1 = store
- d_dmtype  in  3  access size/sign, DMType encoding
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse, data
- d_rdata  out  DATA_W  load data; valid when d_ack=1; 0 for stores
- d_stall  out  1  d_req & ~d_ack (combinational)
- mem_req  out  1  memory request; held until mem_ready
- mem_we  out  1  memory write enable
- mem_dmtype  out  3  size/sign to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ready
- mem_ready  in  1  memory completion; sampled only while mem_req=1
- busy  out  1  state != IDLE
- grant_d  out  1  1 = data side owns the bus (meaningful in DBUSY)

Behaviour:
- States: IDLE, IBUSY, DBUSY. State encoding is 2 bits.
- Register last_grant is 1 bit: 0 = I, 1 = D.
- Reset values: state=IDLE, last_grant=0. All registered outputs (i_ack, d_ack, i_rdata, d_rdata, mem_*, grant_d) are 0.
- Eligibility:
  - i_eff = i_req & ~i_ack
  - d_eff = d_req & ~d_ack
  - This blocks re-granting a requester whose req is still high in its ack cycle.
- IDLE transitions:
  - d_eff & ~i_eff -> DBUSY.
  - i_eff & ~d_eff -> IBUSY.
  - Both eligible -> DBUSY if last_grant=0, else IBUSY.
  - On grant: latch the command into the mem_* registers, set last_grant, set mem_req=1 on the next edge. For an I grant: mem_we=0, mem_dmtype=word.
- BUSY transitions:
  - Hold mem_* stable.
  - On mem_ready=1: capture mem_rdata into i_rdata or d_rdata. For stores, d_rdata=0.
  - Next edge: pulse the matching ack for exactly 1 cycle, drop mem_req, return to IDLE.
- Latency:
  - Request seen in cycle N -> mem_req=1 in N+1.
  - With mem_ready=1 in N+1 -> ack in N+2.
  - Minimum is 2 cycles. An unbroken stream delivers one access per 2 cycles.
- Pipeline rule: the core must hold i_addr/d_* stable while its stall is high.
- Boundary conditions:
  - mem_ready while IDLE is ignored.
  - A requester dropping its req mid-transaction does not abort the transaction; the ack is still issued.
  - Reset mid-transaction -> IDLE next edge, mem_req=0, no ack issued.
  - Acks are never simultaneous.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - Adds output timeout_err (1-bit sticky, cleared only by reset).
  - An 8-bit busy counter counts cycles in IBUSY/DBUSY and resets on each grant.
  - If the counter reaches TIMEOUT without mem_ready: set timeout_err, issue the owning ack with rdata=32'hDEADBEEF, return to IDLE.
- When undefined: no port and no counter; the arbiter waits indefinitely.

Decomposition:
- Shared definitions header, alongside the existing DMType/WDSel encodings:
  - State encodings ARB_IDLE=2'b00, ARB_IBUSY=2'b01, ARB_DBUSY=2'b10.
  - ARB_TIMEOUT_DATA=32'hDEADBEEF.
- Optional sub-module unified_mem_arbiter_watchdog (counter + compare), instantiated only under MEM_ARB_TIMEOUT_EN.

Test Plan:
- i_req=1, i_addr=0x10, mem_ready=1 on first mem_req cycle, mem_rdata=0x00000013 -> mem_addr=0x10, mem_we=0; i_ack pulses 2 cycles after req with i_rdata=0x13; i_stall=1 until then.
- Both i_req and d_req rise together right after reset (d_we=1, d_addr=0x200, d_wdata=0xA5A5A5A5) -> D granted first with mem_we=1, mem_wdata=0xA5A5A5A5, d_rdata=0; then I granted; d_ack precedes i_ack by 2 cycles.
- Both held continuously with zero-wait memory -> grants alternate D, I, D, I; no requester is starved; acks spaced 2 cycles.
- Load with mem_ready delayed 5 cycles, mem_rdata=0x12345678 -> mem_* stable for 5 cycles; d_ack 1 cycle after mem_ready with d_rdata=0x12345678.
- reset asserted during DBUSY -> next edge: busy=0, mem_req=0, no d_ack; fresh i_req then serviced normally.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT=4, mem_ready held 0 -> after 4 busy cycles: ack pulse with rdata 0xDEADBEEF, timeout_err=1 and stays set until reset.
